// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline sequencing controller: FSM states,
// DIVU decode constants and the pipeline-control output word.
package pipe_ctrl_pkg;

    localparam int unsigned DIV_CNT_W = 8;
    localparam int unsigned CTRL_W    = 8;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_DIV_WAIT = 1'b1;

    typedef enum logic [0:0] {
        RUN      = ST_RUN,
        DIV_WAIT = ST_DIV_WAIT
    } state_e;

    // DIVU is R-format: SPECIAL opcode with funct 0x1B; shared with the main decoder.
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    // All-zero control word loaded into a pipeline register to form a bubble.
    localparam logic [CTRL_W-1:0] NOP_CTRL = 8'b0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_bubble;
        logic div_busy;
        logic div_done;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RESET    = hz_ctrl_t'(8'b0010_1100);
    localparam hz_ctrl_t CTRL_RUN      = hz_ctrl_t'(8'b1101_0000);
    localparam hz_ctrl_t CTRL_FREEZE   = hz_ctrl_t'(8'b0000_0100);
    localparam hz_ctrl_t CTRL_FLUSH    = hz_ctrl_t'(8'b1111_1000);
    localparam hz_ctrl_t CTRL_LOAD_USE = hz_ctrl_t'(8'b0001_1000);
    localparam hz_ctrl_t CTRL_DIV_WAIT = hz_ctrl_t'(8'b0000_0110);
    localparam hz_ctrl_t CTRL_DIV_DONE = hz_ctrl_t'(8'b1101_0011);

    function automatic logic is_divu(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_SPECIAL) && (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/jump flushes and a
// fixed-latency DIVU freeze, plus saturating stall/flush event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_LATENCY = 32,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             ex_div,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             div_busy,
    output logic             div_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The first DIVU cycle is spent in RUN and the last one at count zero.
    localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_LATENCY - 2);

    state_e               state_q;
    state_e               state_d;
    logic [DIV_CNT_W-1:0] div_cnt_q;
    logic [DIV_CNT_W-1:0] div_cnt_d;
    hz_ctrl_t             ctl;
    logic                 load_use_c;
    logic                 flush_ev;
    logic                 stall_ev;

    // $0 is never a real producer, so it can never cause a stall.
    assign load_use_c = idex_memread && (idex_rt != 5'd0) &&
                        ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        ctl       = CTRL_RUN;
        flush_ev  = 1'b0;
        if (rst) begin
            ctl = CTRL_RESET;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_div) begin
                        ctl       = CTRL_FREEZE;
                        state_d   = DIV_WAIT;
                        div_cnt_d = DIV_LOAD;
                    end else if (ex_branch_taken || ex_jump) begin
                        ctl      = CTRL_FLUSH;
                        flush_ev = 1'b1;
                    end else if (load_use_c) begin
                        ctl = CTRL_LOAD_USE;
                    end
                end
                DIV_WAIT: begin
                    if (div_cnt_q != '0) begin
                        ctl       = CTRL_DIV_WAIT;
                        div_cnt_d = div_cnt_q - DIV_CNT_W'(1);
                    end else begin
                        ctl     = CTRL_DIV_DONE;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d   = RUN;
                    div_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign stall_ev = !rst && !ctl.pc_write;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (stall_ev),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (flush_ev),
        .cnt (flush_cnt)
    );

    assign pc_write     = ctl.pc_write;
    assign ifid_write   = ctl.ifid_write;
    assign ifid_flush   = ctl.ifid_flush;
    assign idex_write   = ctl.idex_write;
    assign idex_bubble  = ctl.idex_bubble;
    assign exmem_bubble = ctl.exmem_bubble;
    assign div_busy     = ctl.div_busy;
    assign div_done     = ctl.div_done;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the 5-stage MIPS pipeline. It sits beside the main decoder and drives the PC and pipeline-register write, flush and bubble controls. It handles three cases:
- load-use stalls, detected in ID against the instruction in EX;
- taken-branch and jump flushes, resolved in EX;
- a fixed-latency multi-cycle DIVU that freezes the front end while it occupies EX.

It also keeps saturating stall and flush performance counters.

Parameters:
DIV_LATENCY, 32, cycles DIVU occupies EX; legal range 2..255.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-high
id_rs  in  5  rs field of instruction in IF/ID
id_rt  in  5  rt field of instruction in IF/ID
id_uses_rt  in  1  ID instruction reads rt (R-format, BEQ, SW)
idex_memread  in  1  MemRead of instruction in ID/EX (LW)
idex_rt  in  5  destination rt of instruction in ID/EX
ex_branch_taken  in  1  Branch AND Zero, evaluated in EX
ex_jump  in  1  J instruction in EX
ex_div  in  1  DIVU instruction in EX
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID cleared to NOP on the next edge
idex_write  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX loaded with all-zero controls
exmem_bubble  out  1  EX/MEM loaded with all-zero controls
div_busy  out  1  controller is in state DIV_WAIT
div_done  out  1  final DIVU cycle; result is valid in EX
stall_cnt  out  CNT_W  cycles with pc_write=0 since reset, saturating
flush_cnt  out  CNT_W  branch/jump flush events since reset, saturating

Behaviour:
- **States:** RUN and DIV_WAIT. A down-counter div_cnt is 8 bits wide.
- **Reset (rst=1, async):**
  - state=RUN, div_cnt=0, stall_cnt=0, flush_cnt=0.
  - All outputs are forced: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1, div_busy=0, div_done=0.
- **Defaults in RUN:** pc_write=1, ifid_write=1, idex_write=1; all flush and bubble outputs 0.
- **RUN priority (highest first):**
  1. **ex_div=1:** freeze. pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1. Next state=DIV_WAIT, div_cnt<=DIV_LATENCY-2.
  2. **ex_branch_taken=1 or ex_jump=1:** flush. pc_write=1 (target), ifid_flush=1, idex_bubble=1, flush_cnt+1.
  3. **Load-use:** condition is idex_memread=1, idex_rt!=0, and (idex_rt==id_rs or (id_uses_rt=1 and idex_rt==id_rt)). Response: pc_write=0, ifid_write=0, idex_bubble=1. Lasts exactly 1 cycle, because next cycle the load has moved to MEM.
- **DIV_WAIT:**
  - While div_cnt!=0: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, div_busy=1; div_cnt decrements.
  - When div_cnt==0: div_busy=1, div_done=1, all write enables=1, exmem_bubble=0; next state=RUN.
  - ex_branch_taken, ex_jump, load-use and a still-high ex_div are all ignored in DIV_WAIT.
- **DIVU timing:** DIVU occupies EX for exactly DIV_LATENCY cycles. The front end is frozen for DIV_LATENCY-1 cycles.
- **Back-to-back DIVU:** a DIVU entering EX on the cycle after div_done restarts the sequence from RUN priority 1.
- **Counters:**
  - stall_cnt increments on every non-reset cycle with pc_write=0.
  - flush_cnt increments once per flush cycle.
  - Both saturate at all-ones and never wrap.
- **Mid-operation reset:** rst during DIV_WAIT returns immediately to RUN with counters cleared. No div_done pulse is produced.
- **Register $0:** idex_rt==0 never causes a load-use stall.

Decomposition:
- A shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, DIV_WAIT);
  - the DIVU opcode/funct constants also used by the main decoder;
  - the NOP control word (8'b0) used by the bubble logic.
- One natural sub-module: sat_counter, parameterised by width with inc/clr inputs, instantiated twice for stall_cnt and flush_cnt.
- The hazard compare and the FSM stay in the top module.

Test Plan:
1. **Load-use:** LW $8 in EX (idex_memread=1, idex_rt=8) with ADDU using rs=8 in ID -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1.
2. **$0 and no-rt cases:** idex_rt=0 with id_rs=0 -> no stall. idex_rt=9 with id_rt=9 and id_uses_rt=0 -> no stall.
3. **Taken BEQ with simultaneous load-use:** ex_branch_taken=1 while the load-use condition is true -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1; stall_cnt unchanged.
4. **DIVU, DIV_LATENCY=4:** ex_div=1 -> pc_write=0 for 3 cycles; div_busy high for 3 cycles; div_done high in the 4th EX cycle with exmem_bubble=0; stall_cnt=3.
5. **Reset mid-DIVU:** assert rst for 1 cycle during DIV_WAIT (cnt=1) -> outputs forced to reset values immediately; after release state=RUN, div_done never pulses, counters=0.
6. **Saturation, CNT_W=4:** hold a load-use stall condition for 20 cycles -> stall_cnt stops at 15.
